// File: rtl/or_bit32_pkg.sv
// Shared constants for the basic element library.
// Holds the default word width and a width-legality helper used at elaboration.
package or_bit32_pkg;

  localparam int WORD_WIDTH = 32;

  // True when w is a power of two and at least 2, i.e. a legal tree width.
  function automatic bit is_tree_width(input int w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/or_bit32_or_bit_2.sv
// Two-input OR cell: the leaf building block of the reduction tree.
module or_bit_2 (
  input  logic a,
  input  logic b,
  output logic o
);

  assign o = a | b;

endmodule

// File: rtl/or_bit32.sv
// Reduction-OR of a WIDTH-bit word as a balanced tree of or_bit_2 cells.
// Gives a same-cycle flag on o and a registered copy on o_r.
// There is no enable and no handshake: a new word may arrive every cycle.
module or_bit32
  import or_bit32_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  output logic             o,
  output logic             o_r
);

  localparam int LEVELS = $clog2(WIDTH);

  if (!is_tree_width(WIDTH)) begin : g_bad_width
    $error("or_bit32: WIDTH must be a power of two and at least 2");
  end

  // Heap-ordered node vector: node i has children 2i+1 and 2i+2.
  // Leaves (the input bits) occupy the top WIDTH slots, the root is node 0.
  logic [2*WIDTH-2:0] w_node;
  logic               r_o;

  assign w_node[2*WIDTH-2:WIDTH-1] = A;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar n = 0; n < (1 << l); n++) begin : g_cell
      localparam int IDX = (1 << l) - 1 + n;
      or_bit_2 u_or (
        .a (w_node[2*IDX+1]),
        .b (w_node[2*IDX+2]),
        .o (w_node[IDX])
      );
    end
  end

  assign o = w_node[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o <= 1'b0;
    end else begin
      r_o <= w_node[0];
    end
  end

  assign o_r = r_o;

endmodule

// File: tb/tb_or_bit32.sv
// Self-checking bench for or_bit32: directed cases plus a randomized
// regression against a behavioural "word is non-zero" reference.
module tb_or_bit32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic        o;
  logic        o_r;

  int n_checks;
  int n_errors;

  logic [0:0] exp_q[$];

  or_bit32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .o   (o),
    .o_r (o_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (A=%08h rst=%0b)", tag, obs, exp, A, rst);
    end
  endtask

  function automatic logic [31:0] ref_flag(input logic [31:0] a);
    return (a != 32'd0) ? 32'd1 : 32'd0;
  endfunction

  // Combinational-only drive: set A, check o shortly after, then hold.
  task automatic drive_comb(input logic [31:0] a, input int hold_ns, input string tag);
    A = a;
    #1;
    check(tag, {31'b0, o}, ref_flag(a));
    #(hold_ns - 1);
  endtask

  // One clocked step: drive at negedge, check o, then check o_r after the edge.
  task automatic step(input logic [31:0] a, input logic r, input string tag);
    logic [0:0] exp_r;
    @(negedge clk);
    A   = a;
    rst = r;
    #1;
    check({tag, "_o"}, {31'b0, o}, ref_flag(a));
    exp_q.push_back(r ? 1'b0 : (a != 32'd0));
    @(posedge clk);
    #1;
    exp_r = exp_q.pop_front();
    check({tag, "_o_r"}, {31'b0, o_r}, {31'b0, exp_r});
  endtask

  initial begin
    logic [31:0] w;
    n_checks = 0;
    n_errors = 0;
    A   = 32'hFFFF_FFFF;
    rst = 1'b1;

    // Reset held two cycles with all ones: o_r cleared, o still live.
    step(32'hFFFF_FFFF, 1'b1, "rst_hold0");
    step(32'hFFFF_FFFF, 1'b1, "rst_hold1");

    // Directed combinational sequence, 100 ns per value.
    @(negedge clk);
    rst = 1'b0;
    drive_comb(32'd0,   100, "dir_0");
    drive_comb(32'd1,   100, "dir_1");
    drive_comb(32'd123, 100, "dir_123");
    drive_comb(32'd4,   100, "dir_4");
    drive_comb(32'd0,   100, "dir_0b");
    drive_comb(32'd2,   100, "dir_2");

    // Walking one plus MSB-only and all-ones boundaries.
    for (int k = 0; k < 32; k++) begin
      drive_comb(32'd1 << k, 10, $sformatf("walk%0d", k));
    end
    drive_comb(32'h8000_0000, 10, "msb");
    drive_comb(32'hFFFF_FFFF, 10, "ones");

    // Pipelined sequence after reset release.
    step(32'd0,         1'b1, "pre_rst");
    step(32'd0,         1'b0, "seq0");
    step(32'd5,         1'b0, "seq5");
    step(32'd0,         1'b0, "seq0b");
    step(32'h0001_0000, 1'b0, "seq16");

    // Mid-stream reset discards the word of that cycle.
    step(32'd7, 1'b0, "mid_pre");
    step(32'd7, 1'b1, "mid_rst");
    step(32'd7, 1'b0, "mid_post");

    // Random regression, half the words forced to zero.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(1, 0) == 0) w = 32'd0;
      else begin
        w = $urandom;
        if ($urandom_range(3, 0) == 0) w = 32'd1 << $urandom_range(31, 0);
      end
      step(w, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
